keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream front end of the door-lock datapath: scans a 4x3 matrix keypad (digits 0-9, * and #) and debounces it.
- Emits the 12-bit one-hot key code consumed by `lockeddoor.inputChar`, plus a one-cycle press strobe.
- Sits between the keypad pins and the lock FSM, in the `clk` domain.

Parameters:
- SCAN_DIV, 4, clocks each row is driven low; legal values are 3 or more.
- DEBOUNCE_CNT, 3, consecutive identical scan frames required to commit a new key state; legal values are 1 or more.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- col_n  in  3  keypad column returns, active low, asynchronous to clk.
- row_n  out  4  keypad row drives, active low, exactly one row low at a time.
- inputChar  out  12  debounced one-hot key code: bit n = digit n (0-9), bit 10 = *, bit 11 = #; all zero when no key is pressed.
- key_strobe  out  1  one-cycle pulse when inputChar takes a new nonzero value.

Behaviour:
- Reset (asynchronous, reset_n low):
  - row_n = 4'b1110.
  - Row index = 0; divider, frame accumulator and stability counter = 0.
  - inputChar = 0; key_strobe = 0.
  - Column synchronizer flops = 3'b111.
- col_n passes through a 2-FF synchronizer before use.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1 per row.
  - On divider = SCAN_DIV-1, the synchronized columns are sampled for the current row, then the row index advances: 0→1→2→3→0.
  - row_n = ~(1 << row index), registered.
  - One frame = 4*SCAN_DIV clocks (16 at defaults).
- Key map (row, col) → code:
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: *, 0, #
  - A sampled low column sets the corresponding code bit in the 12-bit frame accumulator.
- End of frame (sample of row 3): the accumulator is classified:
  - zero → "none"
  - exactly one bit set → "key"
  - two or more bits set → "invalid"
  - The accumulator is then cleared for the next frame.
- Debounce (per frame):
  - If the frame is invalid: stability counter = 0 and the previous-frame register is cleared to an invalid marker. inputChar holds.
  - Else if the frame equals the previous frame: stability counter increments, saturating at DEBOUNCE_CNT.
  - Else: stability counter = 1.
  - Commit occurs when the stability counter reaches DEBOUNCE_CNT and the frame differs from the current inputChar: inputChar ← frame, on the clock after the end-of-frame sample.
- key_strobe:
  - High for exactly the commit cycle, and only when the committed value is nonzero.
  - Release (commit to 0) produces no strobe.
  - A direct A→B transition without release strobes once for B.
- Latency: a key held steady from an arbitrary instant commits within (DEBOUNCE_CNT+1) frames plus 3 clocks (≤ 67 clocks at defaults). Release latency is identical.
- Bounce:
  - A press shorter than DEBOUNCE_CNT consecutive frames never reaches inputChar.
  - Any glitch frame restarts the count.
- Reset mid-scan or mid-debounce: all state returns to reset values immediately. No strobe is generated on reset release.
- inputChar is registered and glitch-free, and never has more than one bit set.

Decomposition:
- Shared package `lockeddoor_pkg`:
  - CHR_0..CHR_9, CHR_s, CHR_p one-hot constants (12-bit).
  - NUM_ROWS = 4, NUM_COLS = 3.
  - The row/col → code keymap function.
  - These are the constants the lock FSM and its benches also use.
- Sub-module `key_debounce`:
  - Frame-level filter: takes the classified frame and a frame_done pulse.
  - Produces inputChar and key_strobe.
  - Parameterized by DEBOUNCE_CNT.
- Scanning, synchronizer and accumulation stay in the top.

Test Plan:
- Reset, no key (col_n = 3'b111) for 200 clocks → row_n cycles 1110, 1101, 1011, 0111 every 4 clocks; inputChar = 0; key_strobe never high.
- Model presses key 5 (pulls col1 low whenever row_n = 4'b1101), held 100 clocks → inputChar = 12'h020 within 67 clocks; key_strobe exactly one pulse; released → inputChar = 0 within 67 clocks, no strobe.
- Press # (row3, col2) for only 2 frames (32 clocks) → inputChar stays 0; no strobe.
- Keys 1 and 2 held together for 100 clocks, after 1 already committed → inputChar holds 12'h002; no strobe; release 2 and keep 1 → still 12'h002, no new strobe.
- Sequence 1,2,3,4,5,6 each held 100 clocks with 100-clock gaps → strobes carry 12'h002, 004, 008, 010, 020, 040 in order; six strobes total.
- Assert reset_n low while key 9 is held mid-debounce → outputs go to reset values immediately; after release with 9 still held → 12'h200 commits after full debounce, one strobe.

Source files
------------

// File: rtl/lockeddoor_pkg.sv
// Shared door-lock constants: one-hot key codes, keypad geometry, keymap and frame classifier.
// The lock FSM and its benches use the same definitions.
package lockeddoor_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int CODE_W   = 12;

  typedef logic [CODE_W-1:0] key_code_t;

  localparam key_code_t CHR_0 = 12'h001;
  localparam key_code_t CHR_1 = 12'h002;
  localparam key_code_t CHR_2 = 12'h004;
  localparam key_code_t CHR_3 = 12'h008;
  localparam key_code_t CHR_4 = 12'h010;
  localparam key_code_t CHR_5 = 12'h020;
  localparam key_code_t CHR_6 = 12'h040;
  localparam key_code_t CHR_7 = 12'h080;
  localparam key_code_t CHR_8 = 12'h100;
  localparam key_code_t CHR_9 = 12'h200;
  localparam key_code_t CHR_s = 12'h400;
  localparam key_code_t CHR_p = 12'h800;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_KEY,
    FRAME_INVALID
  } frame_class_e;

  function automatic key_code_t key_code(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    code = '0;
    case ({row, col})
      4'b00_00: code = CHR_1;
      4'b00_01: code = CHR_2;
      4'b00_10: code = CHR_3;
      4'b01_00: code = CHR_4;
      4'b01_01: code = CHR_5;
      4'b01_10: code = CHR_6;
      4'b10_00: code = CHR_7;
      4'b10_01: code = CHR_8;
      4'b10_10: code = CHR_9;
      4'b11_00: code = CHR_s;
      4'b11_01: code = CHR_0;
      4'b11_10: code = CHR_p;
      default:  code = '0;
    endcase
    return code;
  endfunction

  // Power-of-two test: clearing the lowest set bit leaves zero only for one-hot codes.
  function automatic frame_class_e classify(input key_code_t frame);
    frame_class_e cls;
    if (frame == '0)
      cls = FRAME_NONE;
    else if ((frame & (frame - key_code_t'(1))) == '0)
      cls = FRAME_KEY;
    else
      cls = FRAME_INVALID;
    return cls;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the debounced key code and strobe delivered to the lock FSM.
interface keypad_scanner_if;
  import lockeddoor_pkg::*;

  logic [NUM_COLS-1:0] col_n;
  logic [NUM_ROWS-1:0] row_n;
  key_code_t           inputChar;
  logic                key_strobe;

  modport master (
    input  col_n,
    output row_n,
    output inputChar,
    output key_strobe
  );

  modport slave (
    output col_n,
    input  row_n,
    input  inputChar,
    input  key_strobe
  );
endinterface

// File: rtl/key_debounce.sv
// Frame-level debounce: commits a classified scan frame once it has been stable for
// DEBOUNCE_CNT consecutive frames, strobing on every new nonzero key.
module key_debounce
  import lockeddoor_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         frame_done,
  input  frame_class_e frame_class,
  input  key_code_t    frame_code,
  output key_code_t    inputChar,
  output logic         key_strobe
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] cnt_next;
  key_code_t        prev_code;
  logic             prev_valid;
  logic             commit;

  // NOTE: every signal assigned in always_comb gets a value on every path, or a latch is inferred.
  always_comb begin
    cnt_next = CNT_W'(1);
    if (prev_valid && (frame_code == prev_code))
      cnt_next = (stab_cnt == CNT_MAX) ? CNT_MAX : stab_cnt + CNT_W'(1);
    commit = frame_done && (frame_class != FRAME_INVALID) &&
             (cnt_next == CNT_MAX) && (frame_code != inputChar);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_cnt   <= '0;
      prev_code  <= '0;
      prev_valid <= 1'b0;
      inputChar  <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_done) begin
        if (frame_class == FRAME_INVALID) begin
          // A multi-key frame poisons the history so the next clean frame restarts at 1.
          stab_cnt   <= '0;
          prev_code  <= '0;
          prev_valid <= 1'b0;
        end else begin
          stab_cnt   <= cnt_next;
          prev_code  <= frame_code;
          prev_valid <= 1'b1;
          if (commit) begin
            inputChar  <= frame_code;
            key_strobe <= |frame_code;
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad row scanner: synchronizes the column returns, accumulates one frame of
// key hits across the four rows, classifies it and hands it to the debounce filter.
module keypad_scanner
  import lockeddoor_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input logic             clk,
  input logic             reset_n,
  keypad_scanner_if.master bus
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0]       ROW_LAST = 2'(NUM_ROWS - 1);

  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_sync;
  logic [DIV_W-1:0]    div;
  logic [1:0]          row_idx;
  logic [1:0]          row_next;
  logic [NUM_ROWS-1:0] row_q;
  logic                sample;
  key_code_t           acc;
  key_code_t           acc_next;
  logic                frame_done;
  key_code_t           frame_code;
  frame_class_e        frame_class;
  key_code_t           key_char;
  logic                key_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= bus.col_n;
      col_sync <= col_meta;
    end
  end

  always_comb begin
    sample   = (div == DIV_LAST);
    row_next = row_idx + 2'd1;
    acc_next = acc;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!col_sync[c])
        acc_next = acc_next | key_code(row_idx, 2'(c));
    end
  end

  // Sampling on the last divider count gives the synchronizer time to settle after the row switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      row_idx     <= '0;
      row_q       <= 4'b1110;
      acc         <= '0;
      frame_done  <= 1'b0;
      frame_code  <= '0;
      frame_class <= FRAME_NONE;
    end else begin
      frame_done <= 1'b0;
      if (sample) begin
        div     <= '0;
        row_idx <= row_next;
        row_q   <= ~(4'b0001 << row_next);
        if (row_idx == ROW_LAST) begin
          frame_done  <= 1'b1;
          frame_code  <= acc_next;
          frame_class <= classify(acc_next);
          acc         <= '0;
        end else begin
          acc <= acc_next;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_done (frame_done),
    .frame_class(frame_class),
    .frame_code (frame_code),
    .inputChar  (key_char),
    .key_strobe (key_strobe)
  );

  assign bus.row_n      = row_q;
  assign bus.inputChar  = key_char;
  assign bus.key_strobe = key_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix model closes columns for held keys,
// and each scenario task checks scan order, debounce, strobes and reset behaviour.
module tb_keypad_scanner;

  logic clk;
  logic reset_n;

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pressed[row][col] = 1 closes that switch; a closed switch pulls its column low while its row is driven low.
  logic [3:0][2:0] pressed;

  always_comb begin
    bus.col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r][c] && !bus.row_n[r])
          bus.col_n[c] = 1'b0;
  end

  int          checks;
  int          failures;
  int          strobe_cnt;
  int          multi_hot;
  logic [11:0] strobe_log[$];

  always @(negedge clk) begin
    if (bus.key_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_log.push_back(bus.inputChar);
    end
    if ($countones(bus.inputChar) > 1)
      multi_hot++;
  end

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_char(input logic [11:0] target, input int budget, output int waited);
    waited = 0;
    while (bus.inputChar !== target && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows[4];
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset_n = 1'b0;
    pressed = '0;
    wait_clocks(3);
    checks++;
    if (bus.row_n !== 4'b1110) begin
      failures++;
      $display("FAIL reset_row_n: got %b want 1110", bus.row_n);
    end
    checks++;
    if (bus.inputChar !== 12'h000) begin
      failures++;
      $display("FAIL reset_inputChar: got %h want 000", bus.inputChar);
    end
    checks++;
    if (bus.key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_key_strobe: got %b want 0", bus.key_strobe);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (bus.row_n !== exp_rows[(k / 4) % 4]) begin
        failures++;
        $display("FAIL row_sequence[%0d]: got %b want %b", k, bus.row_n, exp_rows[(k / 4) % 4]);
      end
      @(negedge clk);
    end
    wait_clocks(168);
    checks++;
    if (bus.inputChar !== 12'h000) begin
      failures++;
      $display("FAIL idle_inputChar: got %h want 000", bus.inputChar);
    end
    checks++;
    if (strobe_cnt !== 0) begin
      failures++;
      $display("FAIL idle_strobes: got %0d want 0", strobe_cnt);
    end
  endtask

  task automatic test_press_release();
    int waited;
    int base;
    base = strobe_cnt;
    wait_clocks(7);
    pressed[1][1] = 1'b1;
    wait_char(12'h020, 67, waited);
    checks++;
    if (bus.inputChar !== 12'h020) begin
      failures++;
      $display("FAIL press5_commit: got %h want 020 within 67 clocks", bus.inputChar);
    end
    wait_clocks(100 - waited);
    checks++;
    if (strobe_cnt - base !== 1) begin
      failures++;
      $display("FAIL press5_strobes: got %0d want 1", strobe_cnt - base);
    end
    checks++;
    if (strobe_log.size() == 0 || strobe_log[strobe_log.size() - 1] !== 12'h020) begin
      failures++;
      $display("FAIL press5_strobe_value: log size %0d want last 020", strobe_log.size());
    end
    pressed[1][1] = 1'b0;
    wait_char(12'h000, 67, waited);
    checks++;
    if (bus.inputChar !== 12'h000) begin
      failures++;
      $display("FAIL release5: got %h want 000 within 67 clocks", bus.inputChar);
    end
    wait_clocks(100 - waited);
    checks++;
    if (strobe_cnt - base !== 1) begin
      failures++;
      $display("FAIL release5_strobes: got %0d want 1", strobe_cnt - base);
    end
  endtask

  task automatic test_short_press();
    int base;
    base = strobe_cnt;
    wait_clocks(3);
    pressed[3][2] = 1'b1;
    wait_clocks(32);
    pressed[3][2] = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.inputChar !== 12'h000) begin
        checks++;
        failures++;
        $display("FAIL short_press_char: got %h want 000 at clock %0d", bus.inputChar, k);
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL short_press_strobes: got %0d want 0", strobe_cnt - base);
    end
  endtask

  task automatic test_two_keys();
    int waited;
    int base;
    int bad;
    pressed[0][0] = 1'b1;
    wait_char(12'h002, 67, waited);
    checks++;
    if (bus.inputChar !== 12'h002) begin
      failures++;
      $display("FAIL key1_commit: got %h want 002", bus.inputChar);
    end
    wait_clocks(20);
    base = strobe_cnt;
    pressed[0][1] = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.inputChar !== 12'h002) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL two_keys_hold: %0d clocks with inputChar %h want 002", bad, bus.inputChar);
    end
    pressed[0][1] = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.inputChar !== 12'h002) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL release2_keep1: %0d clocks with inputChar %h want 002", bad, bus.inputChar);
    end
    checks++;
    if (strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL two_keys_strobes: got %0d want 0", strobe_cnt - base);
    end
    pressed[0][0] = 1'b0;
    wait_char(12'h000, 67, waited);
    checks++;
    if (bus.inputChar !== 12'h000) begin
      failures++;
      $display("FAIL key1_release: got %h want 000", bus.inputChar);
    end
    wait_clocks(30);
  endtask

  task automatic test_back_to_back();
    int          seq_row[6];
    int          seq_col[6];
    logic [11:0] seq_code[6];
    int          base;
    seq_row  = '{0, 0, 0, 1, 1, 1};
    seq_col  = '{0, 1, 2, 0, 1, 2};
    seq_code = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040};
    base = strobe_log.size();
    for (int i = 0; i < 6; i++) begin
      pressed[seq_row[i]][seq_col[i]] = 1'b1;
      wait_clocks(100);
      pressed[seq_row[i]][seq_col[i]] = 1'b0;
      wait_clocks(100);
    end
    checks++;
    if (strobe_log.size() - base !== 6) begin
      failures++;
      $display("FAIL sequence_strobe_count: got %0d want 6", strobe_log.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (base + i >= strobe_log.size() || strobe_log[base + i] !== seq_code[i]) begin
        failures++;
        $display("FAIL sequence_strobe[%0d]: got %h want %h", i,
                 (base + i < strobe_log.size()) ? strobe_log[base + i] : 12'hxxx, seq_code[i]);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int waited;
    int base;
    pressed[2][2] = 1'b1;
    wait_clocks(20);
    checks++;
    if (bus.inputChar !== 12'h000) begin
      failures++;
      $display("FAIL key9_early: got %h want 000 before debounce", bus.inputChar);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.row_n !== 4'b1110 || bus.inputChar !== 12'h000 || bus.key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: row_n %b char %h strobe %b want 1110 000 0",
               bus.row_n, bus.inputChar, bus.key_strobe);
    end
    wait_clocks(10);
    base = strobe_cnt;
    reset_n = 1'b1;
    wait_clocks(5);
    checks++;
    if (strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL reset_release_strobe: got %0d want 0", strobe_cnt - base);
    end
    wait_char(12'h200, 67, waited);
    checks++;
    if (bus.inputChar !== 12'h200) begin
      failures++;
      $display("FAIL key9_commit: got %h want 200", bus.inputChar);
    end
    wait_clocks(30);
    checks++;
    if (strobe_cnt - base !== 1 || strobe_log[strobe_log.size() - 1] !== 12'h200) begin
      failures++;
      $display("FAIL key9_strobe: count %0d want 1 with value 200", strobe_cnt - base);
    end
    pressed[2][2] = 1'b0;
    wait_clocks(80);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    strobe_cnt = 0;
    multi_hot  = 0;
    reset_n    = 1'b0;
    pressed    = '0;
    test_reset();
    test_press_release();
    test_short_press();
    test_two_keys();
    test_back_to_back();
    test_reset_mid_debounce();
    checks++;
    if (multi_hot !== 0) begin
      failures++;
      $display("FAIL one_hot: %0d clocks with more than one inputChar bit, want 0", multi_hot);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
